// File: rtl/rop_frag_serializer_pkg.sv
// Shared ROP types: request entry storage, fragment record and serializer sizes.
// Lane count, position and depth widths come from NUM_THREADS / ROP_DIM_BITS / ROP_DEPTH_BITS.
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef ROP_DIM_BITS
`define ROP_DIM_BITS 16
`endif
`ifndef ROP_DEPTH_BITS
`define ROP_DEPTH_BITS 24
`endif
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package rop_types;

    localparam int ROP_NUM_LANES    = `NUM_THREADS;
    localparam int ROP_DIM          = `ROP_DIM_BITS;
    localparam int ROP_DB           = `ROP_DEPTH_BITS;
    localparam int ROP_SER_TID_BITS = `CLOG2(`NUM_THREADS);

    typedef struct packed {
        logic                                        valid;
        logic [ROP_NUM_LANES-1:0]                    tmask;
        logic [ROP_NUM_LANES-1:0][ROP_DIM-1:0]       pos_x;
        logic [ROP_NUM_LANES-1:0][ROP_DIM-1:0]       pos_y;
        logic [ROP_NUM_LANES-1:0][31:0]              color;
        logic [ROP_NUM_LANES-1:0][ROP_DB-1:0]        depth;
        logic [ROP_NUM_LANES-1:0]                    backface;
    } rop_queue_entry;

    typedef struct packed {
        logic [ROP_DIM-1:0]          pos_x;
        logic [ROP_DIM-1:0]          pos_y;
        logic [31:0]                 color;
        logic [ROP_DB-1:0]           depth;
        logic                        backface;
        logic [ROP_SER_TID_BITS-1:0] tid;
    } rop_frag_t;

endpackage

// File: rtl/rop_frag_serializer_select.sv
// Picks the lowest remaining lane of an entry and flags when it is the last one.
// Purely combinational; no state, no backpressure.
module rop_frag_select
    import rop_types::*;
(
    input  logic [ROP_NUM_LANES-1:0]    rem_mask,
    output logic [ROP_SER_TID_BITS-1:0] sel_tid,
    output logic [ROP_NUM_LANES-1:0]    sel_onehot,
    output logic                        is_last
);

    always_comb begin
        sel_tid    = '0;
        sel_onehot = '0;
        // Descending scan so the lowest set bit is the final assignment.
        for (int i = ROP_NUM_LANES - 1; i >= 0; i--) begin
            if (rem_mask[i]) begin
                sel_tid       = ROP_SER_TID_BITS'(i);
                sel_onehot    = '0;
                sel_onehot[i] = 1'b1;
            end
        end
        is_last = (rem_mask != '0) && ((rem_mask & ~sel_onehot) == '0);
    end

endmodule

// File: rtl/rop_frag_serializer.sv
// Buffers warp-wide ROP entries and emits one fragment per cycle, lowest active lane first.
// Latency: accept -> frag_valid one cycle when empty; back-to-back entries without bubbles.
// Backpressure: req_ready = !full (no pop-through); frag held while !frag_ready. ROP_SERIALIZER_PERF_EN adds perf counters.
module rop_frag_serializer
    import rop_types::*;
#(
    parameter int QUEUE_SIZE = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              req_valid,
    input  logic [ROP_NUM_LANES-1:0]          req_tmask,
    input  logic [ROP_NUM_LANES*ROP_DIM-1:0]  req_pos_x,
    input  logic [ROP_NUM_LANES*ROP_DIM-1:0]  req_pos_y,
    input  logic [ROP_NUM_LANES*32-1:0]       req_color,
    input  logic [ROP_NUM_LANES*ROP_DB-1:0]   req_depth,
    input  logic [ROP_NUM_LANES-1:0]          req_backface,
    output logic                              req_ready,
    output logic                              frag_valid,
    output logic [ROP_DIM-1:0]                frag_pos_x,
    output logic [ROP_DIM-1:0]                frag_pos_y,
    output logic [31:0]                       frag_color,
    output logic [ROP_DB-1:0]                 frag_depth,
    output logic                              frag_backface,
    output logic [ROP_SER_TID_BITS-1:0]       frag_tid,
    output logic                              frag_eop,
`ifdef ROP_SERIALIZER_PERF_EN
    output logic [31:0]                       perf_stall_cycles,
    output logic [31:0]                       perf_frags,
`endif
    input  logic                              frag_ready
);

    localparam int AW = $clog2(QUEUE_SIZE);
    localparam int CW = AW + 1;

    rop_queue_entry                 mem [QUEUE_SIZE];
    rop_queue_entry                 req_entry;
    rop_frag_t                      frag;
    logic [AW-1:0]                  wr_ptr, rd_ptr, rd_next;
    logic [CW-1:0]                  count;
    logic [ROP_NUM_LANES-1:0]       rem_mask;
    logic [ROP_SER_TID_BITS-1:0]    sel_tid;
    logic [ROP_NUM_LANES-1:0]       sel_onehot;
    logic                           is_last;
    logic                           has_head, push, fire, pop;

    always_comb begin
        req_entry       = '0;
        req_entry.valid = 1'b1;
        req_entry.tmask = req_tmask;
        req_entry.backface = req_backface;
        for (int l = 0; l < ROP_NUM_LANES; l++) begin
            req_entry.pos_x[l] = req_pos_x[l*ROP_DIM +: ROP_DIM];
            req_entry.pos_y[l] = req_pos_y[l*ROP_DIM +: ROP_DIM];
            req_entry.color[l] = req_color[l*32 +: 32];
            req_entry.depth[l] = req_depth[l*ROP_DB +: ROP_DB];
        end
    end

    rop_frag_select u_select (
        .rem_mask   (rem_mask),
        .sel_tid    (sel_tid),
        .sel_onehot (sel_onehot),
        .is_last    (is_last)
    );

    assign has_head  = (count != '0);
    assign req_ready = (count != CW'(QUEUE_SIZE));
    // Empty-mask entries are acknowledged but never stored.
    assign push      = req_valid && req_ready && (req_tmask != '0);
    assign fire      = has_head && frag_ready;
    assign pop       = fire && is_last;
    assign rd_next   = rd_ptr + AW'(1);

    always_comb begin
        frag = '0;
        if (has_head) begin
            frag.pos_x    = mem[rd_ptr].pos_x[sel_tid];
            frag.pos_y    = mem[rd_ptr].pos_y[sel_tid];
            frag.color    = mem[rd_ptr].color[sel_tid];
            frag.depth    = mem[rd_ptr].depth[sel_tid];
            frag.backface = mem[rd_ptr].backface[sel_tid];
            frag.tid      = sel_tid;
        end
    end

    assign frag_valid    = has_head;
    assign frag_eop      = has_head && is_last;
    assign frag_pos_x    = frag.pos_x;
    assign frag_pos_y    = frag.pos_y;
    assign frag_color    = frag.color;
    assign frag_depth    = frag.depth;
    assign frag_backface = frag.backface;
    assign frag_tid      = frag.tid;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= req_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rem_mask <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_next;
            count <= count + CW'(push) - CW'(pop);
            // The next head's mask loads on the popping edge so entries run back to back.
            if (pop) begin
                if (count > CW'(1))
                    rem_mask <= mem[rd_next].tmask;
                else if (push)
                    rem_mask <= req_tmask;
                else
                    rem_mask <= '0;
            end else if (fire) begin
                rem_mask <= rem_mask & ~sel_onehot;
            end else if (!has_head && push) begin
                rem_mask <= req_tmask;
            end
        end
    end

`ifdef ROP_SERIALIZER_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cycles <= '0;
            perf_frags        <= '0;
        end else begin
            if (has_head && !frag_ready) perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (fire)                    perf_frags        <= perf_frags + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rop_frag_serializer.sv
// Directed and randomized checks of rop_frag_serializer with hand-computed fragment expectations.
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef ROP_DIM_BITS
`define ROP_DIM_BITS 16
`endif
`ifndef ROP_DEPTH_BITS
`define ROP_DEPTH_BITS 24
`endif

module tb_rop_frag_serializer;
    import rop_types::*;

    localparam int L   = ROP_NUM_LANES;
    localparam int DIM = ROP_DIM;
    localparam int DB  = ROP_DB;
    localparam int TB  = ROP_SER_TID_BITS;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 req_valid;
    logic [L-1:0]         req_tmask;
    logic [L*DIM-1:0]     req_pos_x, req_pos_y;
    logic [L*32-1:0]      req_color;
    logic [L*DB-1:0]      req_depth;
    logic [L-1:0]         req_backface;
    logic                 req_ready;
    logic                 frag_valid;
    logic [DIM-1:0]       frag_pos_x, frag_pos_y;
    logic [31:0]          frag_color;
    logic [DB-1:0]        frag_depth;
    logic                 frag_backface;
    logic [TB-1:0]        frag_tid;
    logic                 frag_eop;
    logic                 frag_ready;
`ifdef ROP_SERIALIZER_PERF_EN
    logic [31:0]          perf_stall_cycles, perf_frags;
`endif

    int tests = 0;
    int fails = 0;

    rop_frag_serializer #(.QUEUE_SIZE(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_tmask     (req_tmask),
        .req_pos_x     (req_pos_x),
        .req_pos_y     (req_pos_y),
        .req_color     (req_color),
        .req_depth     (req_depth),
        .req_backface  (req_backface),
        .req_ready     (req_ready),
        .frag_valid    (frag_valid),
        .frag_pos_x    (frag_pos_x),
        .frag_pos_y    (frag_pos_y),
        .frag_color    (frag_color),
        .frag_depth    (frag_depth),
        .frag_backface (frag_backface),
        .frag_tid      (frag_tid),
        .frag_eop      (frag_eop),
`ifdef ROP_SERIALIZER_PERF_EN
        .perf_stall_cycles (perf_stall_cycles),
        .perf_frags        (perf_frags),
`endif
        .frag_ready    (frag_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [DIM-1:0] fx(input int e, input int l);
        return DIM'({e[7:0], l[7:0]});
    endfunction
    function automatic logic [DIM-1:0] fy(input int e, input int l);
        return DIM'({l[7:0], e[7:0]} ^ 16'h5a5a);
    endfunction
    function automatic logic [31:0] fc(input int e, input int l);
        return {8'ha5, e[7:0], 8'h3c, l[7:0]};
    endfunction
    function automatic logic [DB-1:0] fd(input int e, input int l);
        return DB'({e[7:0], 8'h77, l[7:0]});
    endfunction
    function automatic logic fb(input int e, input int l);
        return e[0] ^ l[0];
    endfunction

    function automatic logic [127:0] exp_vec(input int e, input int l, input logic eop);
        return 128'({1'b1, fx(e, l), fy(e, l), fc(e, l), fd(e, l), fb(e, l), TB'(l), eop});
    endfunction
    function automatic logic [127:0] cur_vec();
        return 128'({frag_valid, frag_pos_x, frag_pos_y, frag_color, frag_depth,
                     frag_backface, frag_tid, frag_eop});
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic v, input int e, input logic [L-1:0] m);
        req_valid = v;
        req_tmask = m;
        for (int l = 0; l < L; l++) begin
            req_pos_x[l*DIM +: DIM] = fx(e, l);
            req_pos_y[l*DIM +: DIM] = fy(e, l);
            req_color[l*32 +: 32]   = fc(e, l);
            req_depth[l*DB +: DB]   = fd(e, l);
            req_backface[l]         = fb(e, l);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_frag(input string tag, input int e, input int l, input logic eop);
        check({tag, "_frag"}, cur_vec(), exp_vec(e, l, eop));
    endtask

    logic [127:0] sb[$];
    logic [127:0] prev_vec;
    logic         prev_hold;
    int           n_ent;
    logic         rv;
    logic [L-1:0] rm;
    int           last_l;

    initial begin
        reset = 1'b1;
        frag_ready = 1'b1;
        set_req(1'b0, 0, '0);
        repeat (3) step();
        check("rst_valid", frag_valid, 0);
        check("rst_eop",   frag_eop, 0);
        check("rst_ready", req_ready, 1);
        check("rst_data",  {frag_pos_x, frag_pos_y, frag_color, frag_depth, frag_backface, frag_tid}, 0);
        reset = 1'b0;
        step();
        check("idle_valid", frag_valid, 0);

        // Single entry 1011: tid 0,1,3, eop only on 3, first frag one cycle after accept.
        set_req(1'b1, 1, 4'b1011);
        check("t1_pre", frag_valid, 0);
        step();
        set_req(1'b0, 0, '0);
        chk_frag("t1_f0", 1, 0, 1'b0);
        step();
        chk_frag("t1_f1", 1, 1, 1'b0);
        step();
        chk_frag("t1_f3", 1, 3, 1'b1);
        step();
        check("t1_done", frag_valid, 0);

        // Back-to-back 1111 then 0001.
        set_req(1'b1, 2, 4'b1111);
        step();
        set_req(1'b1, 3, 4'b0001);
        check("t2_ready", req_ready, 1);
        chk_frag("t2_c1", 2, 0, 1'b0);
        step();
        set_req(1'b0, 0, '0);
        chk_frag("t2_c2", 2, 1, 1'b0);
        step();
        chk_frag("t2_c3", 2, 2, 1'b0);
        step();
        chk_frag("t2_c4", 2, 3, 1'b1);
        step();
        chk_frag("t2_c5", 3, 0, 1'b1);
        step();
        check("t2_done", frag_valid, 0);

        // Empty-mask entry between two real ones.
        set_req(1'b1, 4, 4'b0110);
        step();
        set_req(1'b1, 5, 4'b0000);
        check("t3_ready0", req_ready, 1);
        chk_frag("t3_a1", 4, 1, 1'b0);
        step();
        set_req(1'b1, 6, 4'b1001);
        chk_frag("t3_a2", 4, 2, 1'b1);
        step();
        set_req(1'b0, 0, '0);
        chk_frag("t3_b0", 6, 0, 1'b0);
        step();
        chk_frag("t3_b3", 6, 3, 1'b1);
        step();
        check("t3_done", frag_valid, 0);

        // Ten stalled cycles: FIFO fills after four accepts, head stays put.
        frag_ready = 1'b0;
        for (int s = 0; s <= 10; s++) begin
            if (s < 4) set_req(1'b1, 10 + s, 4'b0011);
            else       set_req(1'b1, 99, 4'b0011);
            check($sformatf("t4_ready_s%0d", s), req_ready, (s < 4) ? 1 : 0);
            if (s >= 1) chk_frag($sformatf("t4_hold_s%0d", s), 10, 0, 1'b0);
            step();
        end
        set_req(1'b0, 0, '0);
        check("t4_full", req_ready, 0);
`ifdef ROP_SERIALIZER_PERF_EN
        check("t4_perf_stall", perf_stall_cycles, 10);
        check("t4_perf_frags", perf_frags, 12);
`endif
        frag_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            chk_frag($sformatf("t4_drain%0d", j), 10 + j / 2, j % 2, (j % 2) == 1);
            step();
        end
        check("t4_done", frag_valid, 0);
`ifdef ROP_SERIALIZER_PERF_EN
        check("t4_perf_frags2", perf_frags, 20);
`endif

        // Reset while two lanes of the head remain.
        set_req(1'b1, 20, 4'b0111);
        step();
        set_req(1'b0, 0, '0);
        chk_frag("t5_f0", 20, 0, 1'b0);
        step();
        chk_frag("t5_f1", 20, 1, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t5_valid", frag_valid, 0);
        check("t5_ready", req_ready, 1);
        check("t5_eop",   frag_eop, 0);
`ifdef ROP_SERIALIZER_PERF_EN
        check("t5_perf", {perf_stall_cycles, perf_frags}, 0);
`endif
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("t5_stale%0d", k), frag_valid, 0);
        end

        // Randomized traffic against a per-lane scoreboard.
        n_ent = 100;
        prev_hold = 1'b0;
        prev_vec = '0;
        for (int c = 0; c < 400; c++) begin
            if (c < 300) begin
                rv = 1'($urandom_range(0, 1));
                rm = L'($urandom_range(0, (1 << L) - 1));
                frag_ready = ($urandom_range(0, 3) != 0);
            end else begin
                rv = 1'b0;
                rm = '0;
                frag_ready = 1'b1;
            end
            set_req(rv, n_ent, rm);
            if (prev_hold) check("rnd_hold", cur_vec(), prev_vec);
            if (frag_valid && frag_ready) begin
                if (sb.size() == 0) check("rnd_extra", 1, 0);
                else                check("rnd_frag", cur_vec(), sb.pop_front());
            end
            prev_hold = frag_valid && !frag_ready;
            prev_vec  = cur_vec();
            if (rv && req_ready) begin
                last_l = -1;
                for (int l = 0; l < L; l++) if (rm[l]) last_l = l;
                for (int l = 0; l < L; l++)
                    if (rm[l]) sb.push_back(exp_vec(n_ent, l, l == last_l));
                n_ent++;
            end
            step();
        end
        check("rnd_empty", sb.size(), 0);
        check("rnd_idle", frag_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
